// File: rtl/sha256_host_ctrl.sv
// Host-side controller for a SHA-256 engine: streams message words into shared
// memory, kicks the engine, then reads the 8-word digest back out as strobes.
module sha256_host_ctrl #(
    parameter int unsigned NUM_OF_WORDS = 20,
    parameter logic [15:0] MSG_ADDR     = 16'h0000,
    parameter logic [15:0] OUT_ADDR     = 16'h0100,
    parameter int unsigned DONE_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        sha_start,
    input  logic        sha_done,
    output logic [15:0] sha_message_addr,
    output logic [15:0] sha_output_addr,
    output logic        mem_sel,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data,
    output logic        digest_valid,
    output logic [31:0] digest_word,
    output logic [2:0]  digest_idx,
    output logic        digest_last,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_BUSY, WAIT_DONE, READ, DRAIN
    } state_t;

    localparam logic [7:0] LAST_WORD = 8'(NUM_OF_WORDS);
    localparam logic [7:0] TO_LAST   = 8'(DONE_TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic        ready_en;
    logic        accept;
    logic        load_full;
    logic        timeout;
    logic [7:0]  word_cnt;
    logic [7:0]  to_cnt;
    logic [2:0]  rd_cnt;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        rd_pend;
    logic [2:0]  rd_idx_q;

    assign sha_message_addr = MSG_ADDR;
    assign sha_output_addr  = OUT_ADDR;

    assign accept    = s_valid && s_ready;
    assign load_full = (word_cnt == LAST_WORD);
    // The START cycle counts as the first of the DONE_TIMEOUT cycles.
    assign timeout   = (state == WAIT_BUSY) && sha_done && (to_cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (accept) next_state = LOAD;
            LOAD:      if (load_full) next_state = START;
            START:     next_state = WAIT_BUSY;
            WAIT_BUSY: begin
                if (!sha_done)    next_state = WAIT_DONE;
                else if (timeout) next_state = IDLE;
            end
            WAIT_DONE: if (sha_done) next_state = READ;
            READ:      if (rd_cnt == 3'd7) next_state = DRAIN;
            // Last read is in flight; digest_last lands as IDLE is re-entered.
            DRAIN:     next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    always_comb begin
        s_ready        = ready_en && ((state == IDLE) || ((state == LOAD) && !load_full));
        sha_start      = (state == START);
        mem_we         = wr_en;
        mem_sel        = wr_en || (state == READ);
        mem_addr       = (state == READ) ? (OUT_ADDR + 16'(rd_cnt)) : wr_addr;
        mem_write_data = wr_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en     <= 1'b0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            word_cnt     <= '0;
            to_cnt       <= '0;
            rd_cnt       <= '0;
            rd_pend      <= 1'b0;
            rd_idx_q     <= '0;
            err          <= 1'b0;
            digest_valid <= 1'b0;
            digest_word  <= '0;
            digest_idx   <= '0;
            digest_last  <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            wr_en    <= accept;
            if (accept) begin
                wr_addr  <= MSG_ADDR + 16'(word_cnt);
                wr_data  <= s_data;
                word_cnt <= word_cnt + 8'd1;
            end else if (state == START) begin
                word_cnt <= '0;
            end

            if ((state == IDLE) && accept) err <= 1'b0;
            else if (timeout)              err <= 1'b1;

            if (state == START)                     to_cnt <= 8'd1;
            else if ((state == WAIT_BUSY) && sha_done) to_cnt <= to_cnt + 8'd1;

            if (state == READ) rd_cnt <= rd_cnt + 3'd1;
            else               rd_cnt <= '0;

            // Read data arrives one cycle after the address, then is registered.
            rd_pend      <= (state == READ);
            rd_idx_q     <= rd_cnt;
            digest_valid <= rd_pend;
            digest_last  <= rd_pend && (rd_idx_q == 3'd7);
            if (rd_pend) begin
                digest_word <= mem_read_data;
                digest_idx  <= rd_idx_q;
            end
        end
    end

endmodule
